// File: rtl/kart_motion_ctrl_if.sv
// Kart controls, trig ROM port and committed pose, bundled for the motion controller.
// The slave modport is the controller side; master is the game-logic/ROM side.
interface kart_motion_ctrl_if;
   logic               frame_start_in;
   logic               race_active_in;
   logic               left_in;
   logic               right_in;
   logic               accel_in;
   logic               brake_in;
   logic               off_track_in;
   logic        [8:0]  trig_addr_out;
   logic signed [10:0] sin_in;
   logic signed [10:0] cos_in;
   logic        [8:0]  direction_out;
   logic        [10:0] player_x_out;
   logic        [10:0] player_y_out;
   logic        [7:0]  speed_out;
   logic               busy_out;
   logic               update_done_out;

   modport slave (
      input  frame_start_in, race_active_in, left_in, right_in, accel_in, brake_in,
             off_track_in, sin_in, cos_in,
      output trig_addr_out, direction_out, player_x_out, player_y_out, speed_out,
             busy_out, update_done_out
   );

   modport master (
      output frame_start_in, race_active_in, left_in, right_in, accel_in, brake_in,
             off_track_in, sin_in, cos_in,
      input  trig_addr_out, direction_out, player_x_out, player_y_out, speed_out,
             busy_out, update_done_out
   );
endinterface

// File: rtl/kart_motion_ctrl.sv
// Per-frame kart motion update: steer, speed, trig fetch, integrate, commit.
// Frame pulse in cycle 0 -> pose and done pulse in cycle 7; pulses while busy are dropped.
module kart_motion_ctrl #(
   parameter logic [10:0] START_X   = 11'd1024,
   parameter logic [10:0] START_Y   = 11'd1024,
   parameter logic [8:0]  START_DIR = 9'd0,
   parameter logic [7:0]  MAX_SPEED = 8'd64,
   parameter logic [7:0]  ACCEL     = 8'd2,
   parameter logic [7:0]  BRAKE     = 8'd4,
   parameter logic [7:0]  FRICTION  = 8'd1,
   parameter logic [8:0]  TURN_STEP = 9'd3
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   kart_motion_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, TURN, SPEED, ADDR, WAIT1, WAIT2, MOVE, COMMIT} state_t;
   state_t state, state_nxt;

   logic        [8:0]  dir_q, w_dir, trig_addr, dir_turned;
   logic        [7:0]  speed_q, w_speed, spd_new, cap;
   logic        [8:0]  spd_raw;
   logic        [10:0] x_q, y_q, nx_clamped, ny_clamped;
   logic               w_race, w_accel, w_brake, w_off;
   logic signed [10:0] sin_q, cos_q;
   logic signed [19:0] spd_s, sin_s, cos_s, prod_x, prod_y, dx, dy, nx, ny;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.frame_start_in) state_nxt = TURN;
         TURN:    state_nxt = SPEED;
         SPEED:   state_nxt = ADDR;
         ADDR:    state_nxt = WAIT1;
         WAIT1:   state_nxt = WAIT2;
         WAIT2:   state_nxt = MOVE;
         MOVE:    state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy_out        = (state != IDLE);
      bus.update_done_out = (state == COMMIT);
   end

   // Steering reads the live inputs in TURN; the same cycle latches them for later states.
   always_comb begin
      dir_turned = dir_q;
      if (bus.race_active_in && speed_q != 8'd0) begin
         if (bus.right_in && !bus.left_in)
            dir_turned = (dir_q >= 9'd360 - TURN_STEP) ? dir_q + TURN_STEP - 9'd360
                                                       : dir_q + TURN_STEP;
         else if (bus.left_in && !bus.right_in)
            dir_turned = (dir_q < TURN_STEP) ? dir_q + 9'd360 - TURN_STEP
                                             : dir_q - TURN_STEP;
      end
   end

   always_comb begin
      cap = w_off ? (MAX_SPEED >> 1) : MAX_SPEED;
      if (!w_race)
         spd_raw = 9'd0;
      else if (w_brake)
         spd_raw = (speed_q < BRAKE) ? 9'd0 : {1'b0, speed_q - BRAKE};
      else if (w_accel)
         spd_raw = {1'b0, speed_q} + {1'b0, ACCEL};
      else
         spd_raw = (speed_q < FRICTION) ? 9'd0 : {1'b0, speed_q - FRICTION};
      spd_new = (spd_raw > {1'b0, cap}) ? cap : spd_raw[7:0];
   end

   // Signed 20-bit products; >>> 9 floors toward negative infinity.
   always_comb begin
      spd_s  = {12'd0, w_speed};
      sin_s  = {{9{sin_q[10]}}, sin_q};
      cos_s  = {{9{cos_q[10]}}, cos_q};
      prod_x = spd_s * sin_s;
      prod_y = spd_s * cos_s;
      dx     = prod_x >>> 9;
      dy     = prod_y >>> 9;
      nx     = {9'd0, x_q} + dx;
      ny     = {9'd0, y_q} - dy;
      nx_clamped = nx[19] ? 11'd0 : (nx > 20'sd2047) ? 11'd2047 : nx[10:0];
      ny_clamped = ny[19] ? 11'd0 : (ny > 20'sd2047) ? 11'd2047 : ny[10:0];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         dir_q     <= START_DIR;
         w_dir     <= START_DIR;
         trig_addr <= START_DIR;
         x_q       <= START_X;
         y_q       <= START_Y;
         speed_q   <= 8'd0;
         w_speed   <= 8'd0;
         w_race    <= 1'b0;
         w_accel   <= 1'b0;
         w_brake   <= 1'b0;
         w_off     <= 1'b0;
         sin_q     <= 11'sd0;
         cos_q     <= 11'sd0;
      end else begin
         case (state)
            TURN: begin
               w_dir   <= dir_turned;
               w_race  <= bus.race_active_in;
               w_accel <= bus.accel_in;
               w_brake <= bus.brake_in;
               w_off   <= bus.off_track_in;
            end
            SPEED: w_speed   <= spd_new;
            ADDR:  trig_addr <= w_dir;
            WAIT2: begin
               sin_q <= bus.sin_in;
               cos_q <= bus.cos_in;
            end
            // Loading the pose on this edge makes it visible alongside the done pulse.
            MOVE: begin
               dir_q   <= w_dir;
               speed_q <= w_speed;
               x_q     <= nx_clamped;
               y_q     <= ny_clamped;
            end
            default: ;
         endcase
      end
   end

   assign bus.trig_addr_out = trig_addr;
   assign bus.direction_out = dir_q;
   assign bus.player_x_out  = x_q;
   assign bus.player_y_out  = y_q;
   assign bus.speed_out     = speed_q;

endmodule

// File: tb/tb_kart_motion_ctrl.sv
// Randomized bench for kart_motion_ctrl against a frame-level pose model.
module tb_kart_motion_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   kart_motion_ctrl_if bus();

   kart_motion_ctrl dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   int m_dir, m_speed, m_x, m_y;

   function automatic int trig_val(int deg, bit use_cos);
      real rad, r;
      rad = real'(deg) * 3.14159265358979 / 180.0;
      r = (use_cos ? $cos(rad) : $sin(rad)) * 512.0;
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   // Trig ROM with one register stage behind the address.
   always @(posedge clk) begin
      bus.sin_in <= 11'(trig_val(int'(bus.trig_addr_out), 1'b0));
      bus.cos_in <= 11'(trig_val(int'(bus.trig_addr_out), 1'b1));
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic int clamp_pos(int v);
      return (v < 0) ? 0 : (v > 2047) ? 2047 : v;
   endfunction

   task automatic model_reset();
      m_dir = 0; m_speed = 0; m_x = 1024; m_y = 1024;
   endtask

   task automatic model_frame(input bit race, input bit l, input bit r,
                              input bit a, input bit b, input bit off);
      int cap, s;
      if (!race) begin
         m_speed = 0;
      end else begin
         if (m_speed != 0 && r && !l) m_dir = (m_dir + 3) % 360;
         if (m_speed != 0 && l && !r) m_dir = (m_dir + 357) % 360;
         cap = off ? 32 : 64;
         if (b)      s = (m_speed > 4) ? m_speed - 4 : 0;
         else if (a) s = m_speed + 2;
         else        s = (m_speed > 1) ? m_speed - 1 : 0;
         m_speed = (s > cap) ? cap : s;
      end
      m_x = clamp_pos(m_x + ((m_speed * trig_val(m_dir, 1'b0)) >>> 9));
      m_y = clamp_pos(m_y - ((m_speed * trig_val(m_dir, 1'b1)) >>> 9));
   endtask

   task automatic check_pose(input string tag);
      check({tag, ":dir"},   int'(bus.direction_out), m_dir);
      check({tag, ":x"},     int'(bus.player_x_out),  m_x);
      check({tag, ":y"},     int'(bus.player_y_out),  m_y);
      check({tag, ":speed"}, int'(bus.speed_out),     m_speed);
   endtask

   task automatic run_frame(input bit race, input bit l, input bit r, input bit a,
                            input bit b, input bit off, input bit extra_pulse);
      @(negedge clk);
      bus.race_active_in = race; bus.left_in = l; bus.right_in = r;
      bus.accel_in = a; bus.brake_in = b; bus.off_track_in = off;
      bus.frame_start_in = 1'b1;
      model_frame(race, l, r, a, b, off);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         bus.frame_start_in = extra_pulse && (k == 3);
         if (k == 2) begin
            bus.race_active_in = 1'($urandom); bus.left_in = 1'($urandom);
            bus.right_in = 1'($urandom); bus.accel_in = 1'($urandom);
            bus.brake_in = 1'($urandom); bus.off_track_in = 1'($urandom);
         end
         if (k < 7) begin
            check("busy", int'(bus.busy_out), 1);
            check("done_early", int'(bus.update_done_out), 0);
         end
      end
      check("done", int'(bus.update_done_out), 1);
      check_pose("frame");
      check("trig_addr", int'(bus.trig_addr_out), m_dir);
      if (extra_pulse) begin
         for (int k = 8; k <= 12; k++) begin
            @(negedge clk);
            check("done_once", int'(bus.update_done_out), 0);
            if (k == 8) check("idle_busy", int'(bus.busy_out), 0);
         end
      end
   endtask

   initial begin
      bus.frame_start_in = 1'b0; bus.race_active_in = 1'b1;
      bus.left_in = 1'b0; bus.right_in = 1'b0; bus.accel_in = 1'b0;
      bus.brake_in = 1'b0; bus.off_track_in = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_pose("reset");
      check("reset_busy", int'(bus.busy_out), 0);
      check("reset_done", int'(bus.update_done_out), 0);
      check("reset_trig", int'(bus.trig_addr_out), 0);
      rst_n = 1'b1;

      run_frame(1, 0, 0, 0, 0, 0, 0);
      repeat (40) run_frame(1, 0, 0, 1, 0, 0, 0);
      run_frame(1, 0, 0, 1, 0, 1, 0);
      run_frame(1, 0, 0, 1, 1, 0, 0);
      repeat (3) run_frame(1, 0, 1, 0, 0, 0, 0);
      repeat (4) run_frame(1, 1, 0, 0, 0, 0, 0);
      run_frame(1, 1, 1, 0, 0, 0, 0);
      repeat (8) run_frame(1, 0, 0, 0, 1, 0, 0);
      run_frame(1, 0, 1, 0, 0, 0, 0);
      run_frame(1, 1, 0, 1, 0, 0, 0);
      run_frame(0, 0, 1, 1, 0, 0, 0);
      run_frame(1, 0, 1, 1, 0, 0, 1);

      for (int i = 0; i < 200; i++) begin
         run_frame(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                   ($urandom % 10) < 7, ($urandom % 7) == 0, ($urandom % 5) == 0, 0);
      end

      @(negedge clk);
      bus.accel_in = 1'b1; bus.race_active_in = 1'b1;
      bus.frame_start_in = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.frame_start_in = 1'b0;
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      check_pose("midreset");
      check("midreset_busy", int'(bus.busy_out), 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("midreset_done", int'(bus.update_done_out), 0);
      end
      rst_n = 1'b1;
      run_frame(1, 0, 0, 1, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
